// File: rtl/sargantana_icache_refill_buffer.sv
// rtl/sargantana_icache_refill_buffer.sv - assembles memory beats into a full cache line and writes it to one way SRAM
module sargantana_icache_refill_buffer #(
    parameter int SET_WIDHT  = 256,
    parameter int ADDR_WIDHT = 6,
    parameter int BEAT_WIDTH = 64,
    parameter int WAYS       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     refill_valid_i,
    output logic                     refill_ready_o,
    input  logic [ADDR_WIDHT-1:0]    refill_idx_i,
    input  logic [$clog2(WAYS)-1:0]  refill_way_i,
    input  logic                     beat_valid_i,
    output logic                     beat_ready_o,
    input  logic [BEAT_WIDTH-1:0]    beat_data_i,
    output logic [WAYS-1:0]          way_req_o,
    output logic                     way_we_o,
    output logic [ADDR_WIDHT-1:0]    way_addr_o,
    output logic [SET_WIDHT-1:0]     way_data_o,
    output logic                     refill_done_o
);

    localparam int BEATS = SET_WIDHT / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // A line that is not a whole number of beats, or fits in a single beat, is a configuration error
    if (((SET_WIDHT % BEAT_WIDTH) != 0) || (BEATS < 2)) begin : g_bad_geometry
        $error("SET_WIDHT must be a multiple of BEAT_WIDTH with at least two beats per line");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_WIDHT-1:0]  idx_q;
    logic [WAY_W-1:0]       way_q;
    logic [SET_WIDHT-1:0]   line_q;
    logic                   done_q;
    logic                   req_fire;
    logic                   beat_fire;
    logic                   fill_flush;
    logic [WAYS-1:0]        way_onehot;

    assign req_fire   = refill_valid_i & refill_ready_o;
    assign beat_fire  = beat_valid_i & beat_ready_o;
    assign fill_flush = (state_q == FILL) & flush_i;
    assign way_onehot = {{(WAYS-1){1'b0}}, 1'b1} << way_q;

    // State register; reset forces IDLE without waiting for a clock edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/SRAM strobes; flush only matters while a line is still being gathered
    always_comb begin
        state_d        = state_q;
        refill_ready_o = 1'b0;
        beat_ready_o   = 1'b0;
        way_we_o       = 1'b0;
        way_req_o      = '0;
        case (state_q)
            IDLE: begin
                refill_ready_o = ~flush_i;
                if (refill_valid_i && !flush_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                beat_ready_o = ~flush_i;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (beat_valid_i && (cnt_q == LAST_CNT)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                way_we_o  = 1'b1;
                way_req_o = way_onehot;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, beat counter and line assembly; the line is only exposed to the SRAM once complete
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            way_q  <= '0;
            line_q <= '0;
        end else begin
            if (req_fire) begin
                idx_q <= refill_idx_i;
                way_q <= refill_way_i;
                cnt_q <= '0;
            end
            if (fill_flush) begin
                cnt_q <= '0;
            end else if (beat_fire) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        line_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
                    end
                end
                cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Completion pulse for the cycle following the SRAM write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == WRITE);
        end
    end

    assign way_addr_o    = idx_q;
    assign way_data_o    = line_q;
    assign refill_done_o = done_q;

endmodule

// File: tb/tb_sargantana_icache_refill_buffer.sv
// tb/tb_sargantana_icache_refill_buffer.sv - randomized self-checking bench for the icache refill buffer
module tb_sargantana_icache_refill_buffer;

    localparam int SW    = 256;
    localparam int AW    = 6;
    localparam int BW    = 64;
    localparam int WAYS  = 4;
    localparam int BEATS = SW / BW;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           flush_i;
    logic           refill_valid_i;
    logic           refill_ready_o;
    logic [AW-1:0]  refill_idx_i;
    logic [1:0]     refill_way_i;
    logic           beat_valid_i;
    logic           beat_ready_o;
    logic [BW-1:0]  beat_data_i;
    logic [WAYS-1:0] way_req_o;
    logic           way_we_o;
    logic [AW-1:0]  way_addr_o;
    logic [SW-1:0]  way_data_o;
    logic           refill_done_o;

    sargantana_icache_refill_buffer #(
        .SET_WIDHT  (SW),
        .ADDR_WIDHT (AW),
        .BEAT_WIDTH (BW),
        .WAYS       (WAYS)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_idx_i   (refill_idx_i),
        .refill_way_i   (refill_way_i),
        .beat_valid_i   (beat_valid_i),
        .beat_ready_o   (beat_ready_o),
        .beat_data_i    (beat_data_i),
        .way_req_o      (way_req_o),
        .way_we_o       (way_we_o),
        .way_addr_o     (way_addr_o),
        .way_data_o     (way_data_o),
        .refill_done_o  (refill_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: transaction-level view of the refill in progress
    bit             m_busy;
    bit             m_wr;
    bit             m_done;
    logic [AW-1:0]  m_idx;
    logic [1:0]     m_way;
    logic [BW-1:0]  m_beats[$];
    logic [SW-1:0]  m_line;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_wr   = 1'b0;
        m_done = 1'b0;
        m_idx  = '0;
        m_way  = '0;
        m_beats.delete();
        m_line = '0;
    endtask

    task automatic cycle(input logic rv, input logic [AW-1:0] idx, input logic [1:0] way,
                         input logic bv, input logic [BW-1:0] data, input logic fl);
        logic [WAYS-1:0] exp_req;
        @(negedge clk_i);
        refill_valid_i = rv;
        refill_idx_i   = idx;
        refill_way_i   = way;
        beat_valid_i   = bv;
        beat_data_i    = data;
        flush_i        = fl;
        #1;
        exp_req = m_wr ? (WAYS'(1) << m_way) : '0;
        check("refill_ready", SW'(refill_ready_o), SW'(!m_busy && !m_wr && !fl));
        check("beat_ready",   SW'(beat_ready_o),   SW'(m_busy && !fl));
        check("way_we",       SW'(way_we_o),       SW'(m_wr));
        check("way_req",      SW'(way_req_o),      SW'(exp_req));
        check("way_addr",     SW'(way_addr_o),     SW'(m_idx));
        check("refill_done",  SW'(refill_done_o),  SW'(m_done));
        if (m_wr) check("way_data", way_data_o, m_line);
        m_done = m_wr;
        if (m_wr) begin
            m_wr = 1'b0;
        end else if (m_busy) begin
            if (fl) begin
                m_busy = 1'b0;
                m_beats.delete();
            end else if (bv) begin
                m_beats.push_back(data);
                if (m_beats.size() == BEATS) begin
                    for (int k = 0; k < BEATS; k++) m_line[k*BW +: BW] = m_beats[k];
                    m_beats.delete();
                    m_busy = 1'b0;
                    m_wr   = 1'b1;
                end
            end
        end else if (rv && !fl) begin
            m_busy = 1'b1;
            m_idx  = idx;
            m_way  = way;
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic req(input logic [AW-1:0] idx, input logic [1:0] way);
        cycle(1'b1, idx, way, 1'b0, '0, 1'b0);
    endtask

    task automatic beat(input logic [BW-1:0] d);
        cycle(1'b0, '0, '0, 1'b1, d, 1'b0);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic reset_between_edges(input string tag);
        refill_valid_i = 1'b0;
        beat_valid_i   = 1'b0;
        flush_i        = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check({tag, "_we"},   SW'(way_we_o),      '0);
        check({tag, "_req"},  SW'(way_req_o),     '0);
        check({tag, "_done"}, SW'(refill_done_o), '0);
        check({tag, "_addr"}, SW'(way_addr_o),    '0);
        check({tag, "_data"}, way_data_o,         '0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check({tag, "_ready"}, SW'(refill_ready_o), SW'(1'b1));
    endtask

    initial begin
        logic [BW-1:0] p1, p2, p3, p4;
        p1 = 64'h1111_1111_1111_1111;
        p2 = 64'h2222_2222_2222_2222;
        p3 = 64'h3333_3333_3333_3333;
        p4 = 64'h4444_4444_4444_4444;
        refill_valid_i = 1'b0;
        refill_idx_i   = '0;
        refill_way_i   = '0;
        beat_valid_i   = 1'b0;
        beat_data_i    = '0;
        flush_i        = 1'b0;
        rst_i          = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("reset_we",   SW'(way_we_o),      '0);
        check("reset_req",  SW'(way_req_o),     '0);
        check("reset_done", SW'(refill_done_o), '0);
        check("reset_addr", SW'(way_addr_o),    '0);
        check("reset_data", way_data_o,         '0);
        rst_i = 1'b0;
        #1;
        check("reset_ready", SW'(refill_ready_o), SW'(1'b1));

        // basic back-to-back fill
        req(6'h15, 2'd2);
        beat(p1); beat(p2); beat(p3); beat(p4);
        idle_cycle();
        idle_cycle();
        idle_cycle();

        // gapped beats
        req(6'h0A, 2'd1);
        for (int b = 0; b < BEATS; b++) begin
            beat({$urandom, $urandom});
            if (b != BEATS - 1) repeat (3) idle_cycle();
        end
        repeat (3) idle_cycle();

        // flush mid-fill with a beat offered in the flush cycle, then a clean refill
        req(6'h21, 2'd3);
        beat(p4); beat(p3);
        cycle(1'b0, '0, '0, 1'b1, p2, 1'b1);
        idle_cycle();
        cycle(1'b1, 6'h22, 2'd0, 1'b0, '0, 1'b1);
        req(6'h22, 2'd0);
        beat(p2); beat(p1); beat(p4); beat(p3);
        idle_cycle();
        idle_cycle();

        // flush during the write cycle
        req(6'h3F, 2'd1);
        beat(p1); beat(p3); beat(p2); beat(p4);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle_cycle();
        idle_cycle();

        // back-to-back refills: second request held through write and done cycles
        req(6'h05, 2'd1);
        beat(p1); beat(p2); beat(p3); beat(p4);
        req(6'h33, 2'd3);
        req(6'h33, 2'd3);
        beat(p4); beat(p4); beat(p1); beat(p1);
        idle_cycle();
        idle_cycle();

        // asynchronous reset after one beat, then during a write
        req(6'h2A, 2'd2);
        beat(p1);
        reset_between_edges("rst_fill");
        repeat (6) idle_cycle();
        req(6'h2B, 2'd3);
        beat(p1); beat(p2); beat(p3); beat(p4);
        reset_between_edges("rst_write");
        repeat (3) idle_cycle();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_between_edges("rst_rand");
            end else begin
                cycle($urandom_range(0, 99) < 35,
                      AW'($urandom),
                      2'($urandom),
                      $urandom_range(0, 99) < 60,
                      {$urandom, $urandom},
                      $urandom_range(0, 99) < 5);
            end
        end
        repeat (3) idle_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
